// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshaking at both ends.
// Stage 1 evaluates every datapath in parallel; stage 2 selects the result and resolves compares.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             Sign,
  input  logic [5:0]       ALUFun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outZ,
  output logic             flagZ,
  output logic             flagV,
  output logic             flagN,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  function automatic logic op_legal(input logic [5:0] f);
    logic ok;
    case (f[5:4])
      2'b00: ok = 1'b1;
      2'b01: begin
        case (f[3:0])
          4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b1010: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      2'b10: ok = (f[1:0] != 2'b10);
      2'b11: begin
        case (f[3:1])
          3'b001, 3'b000, 3'b010, 3'b110, 3'b101, 3'b111: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic             s2_adv_s, s1_adv_s, accept_s;
  logic             is_sub_s, z_s, v_s, n_s, err_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] logic_s, shift_s;
  logic [SHW-1:0]   amt_s;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d, s1_logic_q, s1_logic_d, s1_shift_q, s1_shift_d;
  logic             s1_z_q, s1_z_d, s1_v_q, s1_v_d, s1_n_q, s1_n_d, s1_err_q, s1_err_d;
  logic [1:0]       s1_cls_q, s1_cls_d;
  logic [2:0]       s1_cmp_q, s1_cmp_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_z_q, s2_z_d;
  logic             s2_fz_q, s2_fz_d, s2_fv_q, s2_fv_d, s2_fn_q, s2_fn_d, s2_err_q, s2_err_d;
  logic             cmp_flag_s;
  logic [WIDTH-1:0] result_s;

  // Stage 1 datapaths: adder with flags, logic unit, barrel shifter.
  always_comb begin
    is_sub_s = (ALUFun[5:4] == 2'b11) | ((ALUFun[5:4] == 2'b00) & ALUFun[0]);
    amt_s    = inA[SHW-1:0];
    if (is_sub_s) begin
      sum_s = {1'b0, inA} - {1'b0, inB};
    end else begin
      sum_s = {1'b0, inA} + {1'b0, inB};
    end
    z_s = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
    if (Sign) begin
      if (is_sub_s) begin
        v_s = (inA[WIDTH-1] != inB[WIDTH-1]) & (sum_s[WIDTH-1] != inA[WIDTH-1]);
      end else begin
        v_s = (inA[WIDTH-1] == inB[WIDTH-1]) & (sum_s[WIDTH-1] != inA[WIDTH-1]);
      end
      n_s = sum_s[WIDTH-1] ^ v_s;
    end else begin
      // Unsigned: bit WIDTH is carry for add and borrow for subtract.
      v_s = sum_s[WIDTH];
      n_s = is_sub_s & sum_s[WIDTH];
    end
    case (ALUFun[3:0])
      4'b1000: logic_s = inA & inB;
      4'b1110: logic_s = inA | inB;
      4'b0110: logic_s = inA ^ inB;
      4'b0001: logic_s = ~(inA | inB);
      4'b1010: logic_s = inA;
      default: logic_s = {WIDTH{1'b0}};
    endcase
    case (ALUFun[1:0])
      2'b00:   shift_s = inB << amt_s;
      2'b01:   shift_s = inB >> amt_s;
      2'b11:   shift_s = $signed(inB) >>> amt_s;
      default: shift_s = {WIDTH{1'b0}};
    endcase
    err_s = ~op_legal(ALUFun);
  end

  // Stage 2 result selection; compares turn the stage-1 Z/N into a single bit.
  always_comb begin
    case (s1_cmp_q)
      3'b001:  cmp_flag_s = s1_z_q;
      3'b000:  cmp_flag_s = ~s1_z_q;
      3'b010:  cmp_flag_s = s1_n_q;
      3'b110:  cmp_flag_s = s1_n_q | s1_z_q;
      3'b101:  cmp_flag_s = s1_n_q;
      3'b111:  cmp_flag_s = ~s1_n_q & ~s1_z_q;
      default: cmp_flag_s = 1'b0;
    endcase
    if (s1_err_q) begin
      result_s = {WIDTH{1'b0}};
    end else begin
      case (s1_cls_q)
        2'b00:   result_s = s1_sum_q;
        2'b01:   result_s = s1_logic_q;
        2'b10:   result_s = s1_shift_q;
        2'b11:   result_s = {{(WIDTH-1){1'b0}}, cmp_flag_s};
        default: result_s = {WIDTH{1'b0}};
      endcase
    end
  end

  // Handshake and next-state for both pipeline registers.
  always_comb begin
    s2_adv_s   = ~s2_valid_q | out_ready;
    s1_adv_s   = ~s1_valid_q | s2_adv_s;
    accept_s   = in_valid & s1_adv_s;
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_logic_d = s1_logic_q;
    s1_shift_d = s1_shift_q;
    s1_z_d     = s1_z_q;
    s1_v_d     = s1_v_q;
    s1_n_d     = s1_n_q;
    s1_err_d   = s1_err_q;
    s1_cls_d   = s1_cls_q;
    s1_cmp_d   = s1_cmp_q;
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_fz_d    = s2_fz_q;
    s2_fv_d    = s2_fv_q;
    s2_fn_d    = s2_fn_q;
    s2_err_d   = s2_err_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept_s) begin
      s1_sum_d   = sum_s[WIDTH-1:0];
      s1_logic_d = logic_s;
      s1_shift_d = shift_s;
      s1_z_d     = z_s;
      s1_v_d     = v_s;
      s1_n_d     = n_s;
      s1_err_d   = err_s;
      s1_cls_d   = ALUFun[5:4];
      s1_cmp_d   = ALUFun[3:1];
    end else begin
      s1_err_d   = s1_err_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d   = result_s;
        s2_fz_d  = s1_z_q;
        s2_fv_d  = s1_v_q;
        s2_fn_d  = s1_n_q;
        s2_err_d = s1_err_q;
      end else begin
        s2_err_d = s2_err_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= {WIDTH{1'b0}};
      s1_logic_q <= {WIDTH{1'b0}};
      s1_shift_q <= {WIDTH{1'b0}};
      s1_z_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_n_q     <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_cls_q   <= 2'b00;
      s1_cmp_q   <= 3'b000;
      s2_valid_q <= 1'b0;
      s2_z_q     <= {WIDTH{1'b0}};
      s2_fz_q    <= 1'b0;
      s2_fv_q    <= 1'b0;
      s2_fn_q    <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_logic_q <= s1_logic_d;
      s1_shift_q <= s1_shift_d;
      s1_z_q     <= s1_z_d;
      s1_v_q     <= s1_v_d;
      s1_n_q     <= s1_n_d;
      s1_err_q   <= s1_err_d;
      s1_cls_q   <= s1_cls_d;
      s1_cmp_q   <= s1_cmp_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_fz_q    <= s2_fz_d;
      s2_fv_q    <= s2_fv_d;
      s2_fn_q    <= s2_fn_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_q;
  assign outZ      = s2_z_q;
  assign flagZ     = s2_fz_q;
  assign flagV     = s2_fv_q;
  assign flagN     = s2_fn_q;
  assign err       = s2_err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe; expectations come from an arithmetic reference model
// and a FIFO scoreboard of accepted operations.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inA = 32'd0, inB = 32'd0;
  logic        Sign = 1'b0;
  logic [5:0]  ALUFun = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] outZ;
  logic        flagZ, flagV, flagN, err;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, acc_cyc = 0, out_cyc = 0, n_out = 0;
  logic [31:0] last_z;
  logic        last_err, last_fz, last_fv, last_fn;
  logic        stall_q = 1'b0;
  logic [31:0] hold_z;
  logic        hold_err;
  bit          rdone;

  typedef struct {
    logic [31:0] z;
    logic        fz, fv, fn, err, chk;
  } exp_t;
  exp_t sb[$];

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .Sign(Sign), .ALUFun(ALUFun),
    .out_valid(out_valid), .out_ready(out_ready), .outZ(outZ),
    .flagZ(flagZ), .flagV(flagV), .flagN(flagN), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: results from mathematical integers, compares from direct relational operators.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic [5:0] f);
    exp_t e;
    longint sa = longint'($signed(a));
    longint sb2 = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic sub = (f[5:4] == 2'b11) || (f[5:4] == 2'b00 && f[0]);
    longint rs = sub ? sa - sb2 : sa + sb2;
    longint unsigned ru = sub ? ua - ub : ua + ub;
    logic signed [31:0] bsig = b;
    int amt = int'(a[4:0]);
    logic lt = s ? ($signed(a) < $signed(b)) : (a < b);
    logic [3:0] lf = f[3:0];
    e.z   = ru[31:0];
    e.fz  = (a + (sub ? -b : b)) == 32'd0;
    e.fv  = s ? (rs > 64'sd2147483647 || rs < -64'sd2147483648) : (sub ? (a < b) : (ru > 64'hFFFFFFFF));
    e.fn  = s ? (rs < 0) : (sub && (a < b));
    e.err = 1'b0;
    e.chk = 1'b0;
    case (f[5:4])
      2'b00: e.chk = 1'b1;
      2'b01: begin
        if (lf == 4'b1000) e.z = a & b;
        else if (lf == 4'b1110) e.z = a | b;
        else if (lf == 4'b0110) e.z = a ^ b;
        else if (lf == 4'b0001) e.z = ~(a | b);
        else if (lf == 4'b1010) e.z = a;
        else e.err = 1'b1;
      end
      2'b10: begin
        if (f[1:0] == 2'b00) e.z = b << amt;
        else if (f[1:0] == 2'b01) e.z = b >> amt;
        else if (f[1:0] == 2'b11) e.z = bsig >>> amt;
        else e.err = 1'b1;
      end
      default: begin
        e.chk = 1'b1;
        case (f[3:1])
          3'b001:  e.z = {31'd0, a == b};
          3'b000:  e.z = {31'd0, a != b};
          3'b010:  e.z = {31'd0, lt};
          3'b110:  e.z = {31'd0, lt || a == b};
          3'b101:  e.z = {31'd0, lt};
          3'b111:  e.z = {31'd0, !lt && a != b};
          default: begin e.err = 1'b1; e.chk = 1'b0; end
        endcase
      end
    endcase
    if (e.err) e.z = 32'd0;
    return e;
  endfunction

  // Monitor: hold-stability, scoreboard pop on transfer, push on accept.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("hold_z", outZ, hold_z);
        check_eq("hold_err", {31'd0, err}, {31'd0, hold_err});
      end
      if (out_valid && out_ready) begin
        check_eq("out_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("outZ", outZ, e.z);
          check_eq("err", {31'd0, err}, {31'd0, e.err});
          if (e.chk) check_eq("flags", {29'd0, flagZ, flagV, flagN}, {29'd0, e.fz, e.fv, e.fn});
        end
        last_z = outZ; last_err = err; last_fz = flagZ; last_fv = flagV; last_fn = flagN;
        out_cyc = cyc;
        n_out++;
      end
      if (in_valid && in_ready) sb.push_back(model(inA, inB, Sign, ALUFun));
      stall_q  = out_valid && !out_ready;
      hold_z   = outZ;
      hold_err = err;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [5:0] f);
    inA = a; inB = b; Sign = s; ALUFun = f; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !out_valid) break;
    end
    check_eq("drain", sb.size(), 32'd0);
  endtask

  logic [5:0] ops [18] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                           6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110010, 6'b110000,
                           6'b110100, 6'b111100, 6'b111010, 6'b111110, 6'b010011, 6'b100010};
  logic [31:0] corner [5] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_z", outZ, 32'd0);
    check_eq("rst_flags", {28'd0, flagZ, flagV, flagN, err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    send(32'h7FFFFFFF, 32'h1, 1'b1, 6'b000000); drain();
    check_eq("t1_z", last_z, 32'h80000000);
    check_eq("t1_flags", {29'd0, last_fz, last_fv, last_fn}, {29'd0, 3'b010});
    check_eq("t1_latency", out_cyc - acc_cyc, 32'd2);

    send(32'h1, 32'hFFFFFFFF, 1'b0, 6'b110100); drain();
    check_eq("t2_ult", last_z, 32'd1);
    send(32'h1, 32'hFFFFFFFF, 1'b1, 6'b110100); drain();
    check_eq("t2_slt", last_z, 32'd0);

    send(32'd4, 32'h80000010, 1'b0, 6'b100011); drain();
    check_eq("t3_sra", last_z, 32'hF8000001);
    send(32'd31, 32'h80000010, 1'b0, 6'b100001); drain();
    check_eq("t3_srl", last_z, 32'h00000001);
    send(32'd0, 32'h80000010, 1'b0, 6'b100000); drain();
    check_eq("t3_sll0", last_z, 32'h80000010);
    send(32'h24, 32'h80000010, 1'b0, 6'b100000); drain();
    check_eq("t3_sll_lowbits", last_z, 32'h00000100);

    out_ready = 1'b0;
    base = n_out;
    fork
      begin
        send(32'd10, 32'd3, 1'b0, 6'b000000);
        send(32'd10, 32'd3, 1'b0, 6'b000001);
        send(32'hF0, 32'h0F, 1'b0, 6'b011110);
        send(32'd2, 32'h3, 1'b0, 6'b100000);
      end
      begin
        repeat (2) @(posedge clk);
        #2 check_eq("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    check_eq("t4_count", n_out - base, 32'd4);

    send(32'h12345678, 32'h9, 1'b0, 6'b010011); drain();
    check_eq("t5_err", {31'd0, last_err}, 32'd1);
    check_eq("t5_z", last_z, 32'd0);
    send(32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 6'b010110); drain();
    check_eq("t5_xor", last_z, 32'hF00FF00F);
    check_eq("t5_noerr", {31'd0, last_err}, 32'd0);

    out_ready = 1'b0;
    send(32'd1, 32'd2, 1'b0, 6'b000000);
    send(32'd3, 32'd4, 1'b0, 6'b000000);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("t6_z", outZ, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'd5, 32'd5, 1'b0, 6'b110010); drain();
    check_eq("t6_eq", last_z, 32'd1);

    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [5:0] f;
          logic [31:0] b;
          f = ops[$urandom_range(0, 17)];
          b = pick();
          if (f == 6'b111010 || f == 6'b111110) b = 32'd0;
          send(pick(), b, 1'($urandom_range(0, 1)), f);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
